// File: rtl/pushbutton_event_vector_pkg.sv
// Shared types and helpers for the pushbutton event vector.
// State encoding and parameter legality check.
package pushbutton_event_vector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } pb_state_e;

  function automatic bit params_ok(
    input int hold,
    input int rpt,
    input int cw
  );
    int m;
    m = (hold > rpt) ? hold : rpt;
    return (hold >= 2) && (rpt >= 1) &&
           (cw >= 1) && (cw < 31) &&
           ((m - 1) < (1 << cw));
  endfunction

endpackage

// File: rtl/pushbutton_event.sv
// Single-button FSM and counter.
// Emits registered press/release/long/repeat pulses.
module pushbutton_event
  import pushbutton_event_vector_pkg::*;
#(
  parameter int HOLD_LENGTH       = 50,
  parameter int REPEAT_LENGTH     = 10,
  parameter int COUNTER_BIT_WIDTH = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int CW = COUNTER_BIT_WIDTH;
  // Long fires HOLD_LENGTH edges after the press edge.
  localparam logic [CW-1:0] HOLD_TERM =
    CW'(HOLD_LENGTH - 1);
  localparam logic [CW-1:0] RPT_TERM =
    CW'(REPEAT_LENGTH - 1);

  pb_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rpt_q, rpt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!btn_n_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (btn_n_i) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (cnt_q == HOLD_TERM) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (btn_n_i) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (cnt_q == RPT_TERM) begin
          cnt_d = '0;
          rpt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rpt_q;

endmodule

// File: rtl/pushbutton_event_vector.sv
// Vector of independent pushbutton event generators.
// One pushbutton_event instance per debounced input bit.
module pushbutton_event_vector
  import pushbutton_event_vector_pkg::*;
#(
  parameter int SIGNAL_BIT_WIDTH  = 8,
  parameter int HOLD_LENGTH       = 50,
  parameter int REPEAT_LENGTH     = 10,
  parameter int COUNTER_BIT_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SIGNAL_BIT_WIDTH-1:0] signals_debounced_n,
  output logic [SIGNAL_BIT_WIDTH-1:0] pressed,
  output logic [SIGNAL_BIT_WIDTH-1:0] press_pulse,
  output logic [SIGNAL_BIT_WIDTH-1:0] release_pulse,
  output logic [SIGNAL_BIT_WIDTH-1:0] long_pulse,
  output logic [SIGNAL_BIT_WIDTH-1:0] repeat_pulse
);

  if (!params_ok(HOLD_LENGTH, REPEAT_LENGTH,
                 COUNTER_BIT_WIDTH)) begin : g_bad_params
    $error("pushbutton_event_vector: illegal parameters");
  end

  for (genvar i = 0; i < SIGNAL_BIT_WIDTH; i++) begin : g_btn
    pushbutton_event #(
      .HOLD_LENGTH      (HOLD_LENGTH),
      .REPEAT_LENGTH    (REPEAT_LENGTH),
      .COUNTER_BIT_WIDTH(COUNTER_BIT_WIDTH)
    ) u_btn (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_n_i  (signals_debounced_n[i]),
      .pressed_o(pressed[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .long_o   (long_pulse[i]),
      .repeat_o (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_pushbutton_event_vector.sv
// Self-checking bench for pushbutton_event_vector.
// Model plus literal expectations at the key edges.
module tb_pushbutton_event_vector;

  localparam int W    = 8;
  localparam int HOLD = 4;
  localparam int RPT  = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sig;
  logic [W-1:0] pressed, press_p, rel_p, long_p, rpt_p;

  pushbutton_event_vector #(
    .SIGNAL_BIT_WIDTH (W),
    .HOLD_LENGTH      (HOLD),
    .REPEAT_LENGTH    (RPT),
    .COUNTER_BIT_WIDTH(2)
  ) dut (
    .clk                (clk),
    .reset_n            (rst_n),
    .signals_debounced_n(sig),
    .pressed            (pressed),
    .press_pulse        (press_p),
    .release_pulse      (rel_p),
    .long_pulse         (long_p),
    .repeat_pulse       (rpt_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b @%0t",
                  nm, act, exp, $time);
  endtask

  // Model: t = edges since the press edge of each bit.
  logic [W-1:0] e_prs = '0, e_pp = '0, e_rel = '0;
  logic [W-1:0] e_lng = '0, e_rpt = '0;
  bit act_b [W];
  int t [W];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_prs = '0; e_pp = '0; e_rel = '0;
      e_lng = '0; e_rpt = '0;
      for (int i = 0; i < W; i++) begin
        act_b[i] = 0;
        t[i] = 0;
      end
    end else begin
      e_pp = '0; e_rel = '0;
      e_lng = '0; e_rpt = '0;
      for (int i = 0; i < W; i++) begin
        if (!sig[i]) begin
          if (!act_b[i]) begin
            act_b[i] = 1;
            t[i] = 0;
            e_pp[i] = 1'b1;
          end else begin
            t[i]++;
            if (t[i] == HOLD)
              e_lng[i] = 1'b1;
            else if (t[i] > HOLD &&
                     (t[i] - HOLD) % RPT == 0)
              e_rpt[i] = 1'b1;
          end
        end else if (act_b[i]) begin
          act_b[i] = 0;
          e_rel[i] = 1'b1;
        end
        e_prs[i] = act_b[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_pressed", pressed, e_prs);
      chk("m_press",   press_p, e_pp);
      chk("m_release", rel_p,   e_rel);
      chk("m_long",    long_p,  e_lng);
      chk("m_repeat",  rpt_p,   e_rpt);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    sig   = 8'hFF;
    rst_n = 1'b0;
    #12;
    chk("rst_pressed", pressed, 8'h00);
    chk("rst_press",   press_p, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("idle", pressed | press_p | rel_p |
                  long_p | rpt_p, 8'h00);
    end

    // Short press
    sig = 8'hFE;
    edge1();
    chk("sp_press", press_p, 8'h01);
    chk("sp_prs0",  pressed, 8'h01);
    edge1();
    chk("sp_prs1",  pressed, 8'h01);
    chk("sp_nopp",  press_p, 8'h00);
    sig = 8'hFF;
    edge1();
    chk("sp_rel",   rel_p,   8'h01);
    chk("sp_prs2",  pressed, 8'h00);
    edges(3);

    // Long hold with repeats
    sig = 8'hFE;
    edge1();
    chk("lh_press", press_p, 8'h01);
    edges(3);
    chk("lh_nolong", long_p, 8'h00);
    edge1();
    chk("lh_long",  long_p,  8'h01);
    edge1();
    chk("lh_norpt", rpt_p,   8'h00);
    edge1();
    chk("lh_rpt1",  rpt_p,   8'h01);
    edges(2);
    chk("lh_rpt2",  rpt_p,   8'h01);
    edge1();
    sig = 8'hFF;
    edge1();
    chk("lh_rel",   rel_p,   8'h01);
    chk("lh_norpt2", rpt_p,  8'h00);
    edges(3);

    // Release collides with long-press
    sig = 8'hF7;
    edges(4);
    sig = 8'hFF;
    edge1();
    chk("col_rel",  rel_p,   8'h08);
    chk("col_long", long_p,  8'h00);
    edges(3);

    // Independent bits
    sig = 8'hFE;
    edges(2);
    sig = 8'h7E;
    edges(3);
    chk("ind_l0",   long_p,  8'h01);
    edges(2);
    chk("ind_l7",   long_p,  8'h80);
    sig = 8'hFF;
    edges(3);

    // Reset mid-hold
    sig = 8'hFD;
    edges(7);
    chk("rm_held",  pressed, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("rm_prs0",  pressed, 8'h00);
    chk("rm_any0",  press_p | rel_p | long_p |
                    rpt_p, 8'h00);
    #2;
    rst_n = 1'b1;
    edge1();
    chk("rm_press", press_p, 8'h02);
    chk("rm_prs1",  pressed, 8'h02);
    sig = 8'hFF;
    edges(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
